alu_shift_seq: RTL

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

---
 rtl/alu_shift_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// Multi-cycle rotate/shift unit: one single-bit step per clock, x86-style flag results.
// Operand, carry and incoming flags are latched at start, so the inputs may change while busy.
//
// state | meaning
// IDLE  | waiting for start; S and flags hold the last result
// SHIFT | one 1-bit step per edge until the remaining count reaches zero
// DONE  | one-cycle done pulse, then back to IDLE
module alu_shift_seq #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               CLKx4,
  input  logic               RESETn,
  input  logic               start,
  input  logic [2:0]         Operation,
  input  logic               byteWord,
  input  logic [WIDTH-1:0]   A,
  input  logic [COUNT_W-1:0] count,
  input  logic               carryIn,
  input  logic               overflowIn,
  input  logic               negIn,
  input  logic               zeroIn,
  input  logic               parityIn,
  input  logic               auxIn,
  output logic [WIDTH-1:0]   S,
  output logic               F_Carry,
  output logic               F_Overflow,
  output logic               F_Neg,
  output logic               F_Zero,
  output logic               F_Parity,
  output logic               F_Aux,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_RCL = 3'd2;
  localparam logic [2:0] OP_RCR = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_SAR = 3'd7;

  localparam logic [WIDTH-1:0] BYTE_MASK = {{(WIDTH-8){1'b0}}, 8'hFF};
  localparam logic [WIDTH-1:0] WORD_TOP  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] BYTE_TOP  = {{(WIDTH-8){1'b0}}, 8'h80};

  logic [1:0]         state;
  logic [WIDTH-1:0]   data;
  logic               carry;
  logic [2:0]         op;
  logic               isWord;
  logic [COUNT_W-1:0] remain;
  logic               negL, zeroL, parityL, auxL;

  logic [WIDTH-1:0]   inMask;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   topOne;
  logic               topBit;
  logic [WIDTH-1:0]   stepData;
  logic               stepCarry;
  logic               newTop;
  logic               newNext;
  logic               stepOf;
  logic               isRotate;

  assign inMask = byteWord ? {WIDTH{1'b1}} : BYTE_MASK;

  // Byte mode keeps bits above 7 at zero, so a plain shift plus the active-width mask suffices.
  always_comb begin
    mask      = isWord ? {WIDTH{1'b1}} : BYTE_MASK;
    topOne    = isWord ? WORD_TOP : BYTE_TOP;
    topBit    = isWord ? data[WIDTH-1] : data[7];
    stepData  = data;
    stepCarry = carry;
    case (op)
      OP_ROL: begin
        stepCarry = topBit;
        stepData  = ((data << 1) | {{(WIDTH-1){1'b0}}, topBit}) & mask;
      end
      OP_ROR: begin
        stepCarry = data[0];
        stepData  = (data >> 1) | (data[0] ? topOne : '0);
      end
      OP_RCL: begin
        stepCarry = topBit;
        stepData  = ((data << 1) | {{(WIDTH-1){1'b0}}, carry}) & mask;
      end
      OP_RCR: begin
        stepCarry = data[0];
        stepData  = (data >> 1) | (carry ? topOne : '0);
      end
      OP_SHR: begin
        stepCarry = data[0];
        stepData  = data >> 1;
      end
      OP_SAR: begin
        stepCarry = data[0];
        stepData  = (data >> 1) | (topBit ? topOne : '0);
      end
      default: begin
        stepCarry = topBit;
        stepData  = (data << 1) & mask;
      end
    endcase

    newTop  = isWord ? stepData[WIDTH-1] : stepData[7];
    newNext = isWord ? stepData[WIDTH-2] : stepData[6];
    case (op)
      OP_ROR, OP_RCR: stepOf = newTop ^ newNext;
      OP_SHR:         stepOf = topBit;
      OP_SAR:         stepOf = 1'b0;
      default:        stepOf = newTop ^ stepCarry;
    endcase
    isRotate = ~op[2];
  end

  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      data       <= '0;
      carry      <= 1'b0;
      op         <= '0;
      isWord     <= 1'b0;
      remain     <= '0;
      negL       <= 1'b0;
      zeroL      <= 1'b0;
      parityL    <= 1'b0;
      auxL       <= 1'b0;
      S          <= '0;
      F_Carry    <= 1'b0;
      F_Overflow <= 1'b0;
      F_Neg      <= 1'b0;
      F_Zero     <= 1'b0;
      F_Parity   <= 1'b0;
      F_Aux      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data    <= A & inMask;
            carry   <= carryIn;
            op      <= Operation;
            isWord  <= byteWord;
            remain  <= count;
            negL    <= negIn;
            zeroL   <= zeroIn;
            parityL <= parityIn;
            auxL    <= auxIn;
            if (count == '0) begin
              state      <= DONE;
              S          <= A & inMask;
              F_Carry    <= carryIn;
              F_Overflow <= overflowIn;
              F_Neg      <= negIn;
              F_Zero     <= zeroIn;
              F_Parity   <= parityIn;
              F_Aux      <= auxIn;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data   <= stepData;
          carry  <= stepCarry;
          remain <= remain - COUNT_W'(1);
          if (remain == COUNT_W'(1)) begin
            state      <= DONE;
            S          <= stepData;
            F_Carry    <= stepCarry;
            F_Overflow <= stepOf;
            if (isRotate) begin
              F_Neg    <= negL;
              F_Zero   <= zeroL;
              F_Parity <= parityL;
              F_Aux    <= auxL;
            end else begin
              F_Neg    <= newTop;
              F_Zero   <= (stepData == '0);
              F_Parity <= ~^stepData[7:0];
              F_Aux    <= 1'b0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
